// File: rtl/microcode_sequencer.sv
// Microcode control unit: run-time loaded code memory and dispatch table, calls, branches, fault halt.
// Optional loop counter (LDCNT/DJNZ) enabled by defining MICROCODE_SEQUENCER_LOOP_EN.
module microcode_sequencer #(
   parameter int unsigned CTRL_WIDTH   = 32,
   parameter int unsigned DEPTH        = 256,
   parameter int unsigned SEG_COUNT    = 64,
   parameter int unsigned OPCODE_WIDTH = 6,
   parameter int unsigned STACK_DEPTH  = 8,
   parameter int unsigned COND_WIDTH   = 4,
   localparam int unsigned AW  = $clog2(DEPTH),
   localparam int unsigned SPW = $clog2(STACK_DEPTH + 1),
   localparam int unsigned CSW = $clog2(COND_WIDTH),
   localparam int unsigned WW  = 4 + CSW + AW + 1 + CTRL_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    prog_we_i,
   input  logic [AW-1:0]           prog_addr_i,
   input  logic [WW-1:0]           prog_data_i,
   input  logic                    seg_we_i,
   input  logic [OPCODE_WIDTH-1:0] seg_idx_i,
   input  logic [AW-1:0]           seg_addr_i,
   input  logic                    sos_i,
   input  logic [OPCODE_WIDTH-1:0] opcode_i,
   input  logic [COND_WIDTH-1:0]   cond_i,
   output logic [CTRL_WIDTH-1:0]   ctrl_o,
   output logic                    eos_o,
   output logic                    busy_o,
   output logic                    fault_o
);

   localparam int unsigned SIW = $clog2(STACK_DEPTH);

   localparam logic [3:0] OpCallSeg = 4'd1;
   localparam logic [3:0] OpCall    = 4'd2;
   localparam logic [3:0] OpJmp     = 4'd3;
   localparam logic [3:0] OpBrc     = 4'd4;
`ifdef MICROCODE_SEQUENCER_LOOP_EN
   localparam logic [3:0] OpLdCnt   = 4'd5;
   localparam logic [3:0] OpDjnz    = 4'd6;
`endif

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

   state_e                state_q, state_d;
   logic [AW-1:0]         pc_q, pc_d;
   logic [SPW-1:0]        sp_q, sp_d;
   logic                  eos_q, eos_d;
   logic                  push;
   logic [SEG_COUNT-1:0]  seg_valid_q;

   logic [WW-1:0]         code_mem  [DEPTH];
   logic [AW-1:0]         seg_table [SEG_COUNT];
   logic [AW-1:0]         stack_q   [STACK_DEPTH];

`ifdef MICROCODE_SEQUENCER_LOOP_EN
   logic [AW-1:0]         cnt_q, cnt_d, cnt_dec;
`endif

   logic [WW-1:0]           word;
   logic [3:0]              w_op;
   logic [CSW-1:0]          w_csel;
   logic [AW-1:0]           w_arg;
   logic                    w_eos;
   logic [CTRL_WIDTH-1:0]   w_ctrl;
   logic [AW-1:0]           pc_inc;
   logic [SPW-1:0]          sp_dec;
   logic                    stack_full;
   logic [OPCODE_WIDTH-1:0] call_idx;

   assign word       = code_mem[pc_q];
   assign w_ctrl     = word[CTRL_WIDTH-1:0];
   assign w_eos      = word[CTRL_WIDTH];
   assign w_arg      = word[CTRL_WIDTH+1 +: AW];
   assign w_csel     = word[CTRL_WIDTH+1+AW +: CSW];
   assign w_op       = word[WW-1 -: 4];
   assign pc_inc     = (pc_q == AW'(DEPTH - 1)) ? '0 : pc_q + 1'b1;
   assign sp_dec     = sp_q - 1'b1;
   assign stack_full = (sp_q == SPW'(STACK_DEPTH));
   assign call_idx   = w_arg[OPCODE_WIDTH-1:0];

   // Programming is locked out while a segment is executing.
   always_ff @(posedge clk_i) begin
      if (prog_we_i && state_q != StRun) code_mem[prog_addr_i] <= prog_data_i;
      if (seg_we_i && state_q != StRun) seg_table[seg_idx_i] <= seg_addr_i;
      if (push) stack_q[sp_q[SIW-1:0]] <= pc_inc;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         pc_q        <= '0;
         sp_q        <= '0;
         eos_q       <= 1'b0;
         seg_valid_q <= '0;
`ifdef MICROCODE_SEQUENCER_LOOP_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         eos_q   <= eos_d;
         if (seg_we_i && state_q != StRun) seg_valid_q[seg_idx_i] <= 1'b1;
`ifdef MICROCODE_SEQUENCER_LOOP_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      sp_d    = sp_q;
      eos_d   = 1'b0;
      push    = 1'b0;
`ifdef MICROCODE_SEQUENCER_LOOP_EN
      cnt_d   = cnt_q;
      cnt_dec = cnt_q - 1'b1;
`endif
      case (state_q)
         StIdle: begin
            if (sos_i) begin
               if (opcode_i == '1 || !seg_valid_q[opcode_i]) begin
                  state_d = StHalt;
               end else begin
                  pc_d    = seg_table[opcode_i];
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            case (w_op)
               OpCallSeg: begin
                  if (stack_full || !seg_valid_q[call_idx]) begin
                     state_d = StHalt;
                  end else begin
                     push = 1'b1;
                     sp_d = sp_q + 1'b1;
                     pc_d = seg_table[call_idx];
                  end
               end
               OpCall: begin
                  if (stack_full) begin
                     state_d = StHalt;
                  end else begin
                     push = 1'b1;
                     sp_d = sp_q + 1'b1;
                     pc_d = w_arg;
                  end
               end
               OpJmp: pc_d = w_arg;
               OpBrc: pc_d = cond_i[w_csel] ? w_arg : pc_inc;
`ifdef MICROCODE_SEQUENCER_LOOP_EN
               OpLdCnt: begin
                  cnt_d = w_arg;
                  pc_d  = pc_inc;
               end
               OpDjnz: begin
                  cnt_d = cnt_dec;
                  pc_d  = (cnt_dec != '0) ? w_arg : pc_inc;
               end
`endif
               default: begin
                  // NOP: eos on a nested segment returns, at top level it finishes.
                  if (!w_eos) begin
                     pc_d = pc_inc;
                  end else if (sp_q != '0) begin
                     sp_d = sp_dec;
                     pc_d = stack_q[sp_dec[SIW-1:0]];
                  end else begin
                     eos_d   = 1'b1;
                     state_d = StIdle;
                  end
               end
            endcase
         end
         default: state_d = StHalt;
      endcase
   end

   always_comb begin
      busy_o  = (state_q == StRun);
      fault_o = (state_q == StHalt);
      eos_o   = eos_q;
      ctrl_o  = busy_o ? w_ctrl : '0;
   end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed self-checking bench for microcode_sequencer; follows MICROCODE_SEQUENCER_LOOP_EN if defined.
module tb_microcode_sequencer;

   localparam int unsigned CW = 32;
   localparam int unsigned AW = 8;
   localparam int unsigned WW = 4 + 2 + AW + 1 + CW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [WW-1:0] prog_data;
   logic          seg_we;
   logic [5:0]    seg_idx;
   logic [AW-1:0] seg_addr;
   logic          sos;
   logic [5:0]    opcode;
   logic [3:0]    cond;
   logic [CW-1:0] ctrl;
   logic          eos, busy, fault;

   int checks   = 0;
   int failures = 0;

   microcode_sequencer dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .prog_we_i  (prog_we),
      .prog_addr_i(prog_addr),
      .prog_data_i(prog_data),
      .seg_we_i   (seg_we),
      .seg_idx_i  (seg_idx),
      .seg_addr_i (seg_addr),
      .sos_i      (sos),
      .opcode_i   (opcode),
      .cond_i     (cond),
      .ctrl_o     (ctrl),
      .eos_o      (eos),
      .busy_o     (busy),
      .fault_o    (fault)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic prog(input logic [3:0] op, input logic [1:0] csel, input logic [7:0] addr,
                       input logic [7:0] arg, input logic e, input logic [31:0] c);
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = addr;
      prog_data = {op, csel, arg, e, c};
      @(negedge clk);
      prog_we   = 1'b0;
   endtask

   task automatic seg(input logic [5:0] idx, input logic [7:0] addr);
      @(negedge clk);
      seg_we   = 1'b1;
      seg_idx  = idx;
      seg_addr = addr;
      @(negedge clk);
      seg_we   = 1'b0;
   endtask

   // Returns at the negedge of the first RUN cycle.
   task automatic start(input logic [5:0] op);
      @(negedge clk);
      sos    = 1'b1;
      opcode = op;
      @(negedge clk);
      sos    = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("rst_fault", fault, 0);
      check_eq("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Expects ctrl to follow seq, then one eos pulse with busy low.
   task automatic run_seq(input string tag, input logic [5:0] op, input int seq[$]);
      start(op);
      foreach (seq[i]) begin
         check_eq({tag, "_ctrl"}, ctrl, seq[i]);
         check_eq({tag, "_eos0"}, eos, 0);
         step();
      end
      check_eq({tag, "_eos"}, eos, 1);
      check_eq({tag, "_idle"}, busy, 0);
      step();
      check_eq({tag, "_eos_pulse"}, eos, 0);
   endtask

   initial begin
      int loop_seq[$];
      rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      seg_we = 1'b0; seg_idx = '0; seg_addr = '0; sos = 1'b0; opcode = '0; cond = '0;
      #12;
      check_eq("reset_ctrl", ctrl, 0);
      check_eq("reset_eos", eos, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_fault", fault, 0);
      step();
      rst_n = 1'b1;

      seg(3, 10);  prog(0, 0, 10, 0, 0, 1); prog(0, 0, 11, 0, 1, 2);
      seg(1, 20);  prog(2, 0, 20, 30, 0, 20); prog(0, 0, 21, 0, 1, 21); prog(0, 0, 30, 0, 1, 30);
      seg(4, 40);  prog(4, 2, 40, 50, 0, 40); prog(0, 0, 41, 0, 1, 41); prog(0, 0, 50, 0, 1, 50);
      seg(2, 60);  prog(2, 0, 60, 60, 0, 60);
      seg(7, 70);  prog(5, 0, 70, 3, 0, 70); prog(6, 0, 71, 71, 0, 71); prog(0, 0, 72, 0, 1, 72);
      seg(8, 80);  prog(1, 0, 80, 3, 0, 80); prog(0, 0, 81, 0, 1, 81);
      seg(9, 90);  prog(3, 0, 90, 95, 0, 90); prog(0, 0, 95, 0, 1, 95);

      run_seq("basic", 3, '{1, 2});
      run_seq("nested", 1, '{20, 30, 21});
      cond = 4'b0100;
      run_seq("brc_taken", 4, '{40, 50});
      cond = 4'b0000;
      run_seq("brc_fall", 4, '{40, 41});
      run_seq("callseg", 8, '{80, 1, 2, 81});
      run_seq("jmp", 9, '{90, 95});
`ifdef MICROCODE_SEQUENCER_LOOP_EN
      loop_seq = '{70, 71, 71, 71, 72};
`else
      loop_seq = '{70, 71, 72};
`endif
      run_seq("loop", 7, loop_seq);

      // Nine CALLs: eight pushes fill the stack, the ninth faults.
      start(2);
      for (int i = 0; i < 9; i++) begin
         check_eq("ovf_run", {busy, ctrl}, {1'b1, 32'd60});
         step();
      end
      check_eq("ovf_fault", fault, 1);
      check_eq("ovf_ctrl", ctrl, 0);
      check_eq("ovf_busy", busy, 0);
      start(3);
      step();
      check_eq("halt_sticky", fault, 1);
      check_eq("halt_busy", busy, 0);
      do_reset();

      start(6'h3F);
      check_eq("inv_allones", fault, 1);
      do_reset();
      start(5);
      check_eq("inv_unwritten", fault, 1);
      do_reset();
      start(3);
      check_eq("inv_cleared", fault, 1);
      check_eq("inv_cleared_ctrl", ctrl, 0);
      do_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
